// File: rtl/bcd_conv_arbiter_amisha.sv
// Round-robin arbiter sharing one bin2bcd converter among N_REQ clients.
// A watchdog aborts a conversion whose done_tick never arrives.
module bcd_conv_arbiter_amisha #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_amisha,
  input  logic                reset_amisha,
  input  logic [N_REQ-1:0]    req_amisha,
  input  logic [13*N_REQ-1:0] bin_in_amisha,
  output logic [N_REQ-1:0]    ack_amisha,
  output logic [N_REQ-1:0]    done_amisha,
  output logic                err_amisha,
  output logic [15:0]         bcd_out_amisha,
  output logic                busy_amisha,
  output logic                conv_start_amisha,
  output logic [12:0]         conv_bin_amisha,
  input  logic                conv_ready_amisha,
  input  logic                conv_done_tick_amisha,
  input  logic [3:0]          conv_bcd3_amisha,
  input  logic [3:0]          conv_bcd2_amisha,
  input  logic [3:0]          conv_bcd1_amisha,
  input  logic [3:0]          conv_bcd0_amisha
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  done_q;
  logic              err_q;
  logic [15:0]       bcd_q;
  logic              busy_q;
  logic              start_q;
  logic [12:0]       bin_q;

  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     owner_nxt;
  logic [12:0]       op_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_op
    assign op_arr[g] = bin_in_amisha[13*g +: 13];
  end

  // Scan from the highest offset down so the nearest one to ptr wins.
  always_comb begin
    logic [IW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (req_amisha[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ?
                     '0 : owner_q + 1'b1;

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (gnt_vld && conv_ready_amisha) begin
            state_q <= S_START;
            owner_q <= gnt_idx;
            bin_q   <= op_arr[gnt_idx];
            ack_q   <= ONE << gnt_idx;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done_tick_amisha) begin
            bcd_q   <= {conv_bcd3_amisha, conv_bcd2_amisha,
                        conv_bcd1_amisha, conv_bcd0_amisha};
            done_q  <= ONE << owner_q;
            ptr_q   <= owner_nxt;
            state_q <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            bcd_q   <= '0;
            err_q   <= 1'b1;
            done_q  <= ONE << owner_q;
            ptr_q   <= owner_nxt;
            state_q <= S_RESP;
          end else if (!start_q) begin
            // Watchdog starts counting after the start-pulse cycle.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_amisha        = ack_q;
  assign done_amisha       = done_q;
  assign err_amisha        = err_q;
  assign bcd_out_amisha    = bcd_q;
  assign busy_amisha       = busy_q;
  assign conv_start_amisha = start_q;
  assign conv_bin_amisha   = bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter_amisha.sv
// Randomised bench for bcd_conv_arbiter_amisha with a behavioural
// converter stub and a round-robin reference model.
module tb_bcd_conv_arbiter_amisha;

  localparam int N  = 4;
  localparam int TO = 64;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [13*N-1:0] bin_in;
  logic [N-1:0]  ack;
  logic [N-1:0]  done;
  logic          err;
  logic [15:0]   bcd_out;
  logic          busy;
  logic          conv_start;
  logic [12:0]   conv_bin;
  logic          conv_ready;
  logic          done_tick;
  logic [3:0]    d3, d2, d1, d0;

  bcd_conv_arbiter_amisha #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_amisha(clk),
    .reset_amisha(rst_n),
    .req_amisha(req),
    .bin_in_amisha(bin_in),
    .ack_amisha(ack),
    .done_amisha(done),
    .err_amisha(err),
    .bcd_out_amisha(bcd_out),
    .busy_amisha(busy),
    .conv_start_amisha(conv_start),
    .conv_bin_amisha(conv_bin),
    .conv_ready_amisha(conv_ready),
    .conv_done_tick_amisha(done_tick),
    .conv_bcd3_amisha(d3),
    .conv_bcd2_amisha(d2),
    .conv_bcd1_amisha(d1),
    .conv_bcd0_amisha(d0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Converter stub: busy for stub_lat+1 cycles after start, then ticks.
  logic        stub_busy, stub_tick, stub_hold;
  logic        force_nr, force_tick;
  int          stub_lat, stub_cnt;
  logic [12:0] stub_op;

  assign conv_ready = !stub_busy && !force_nr;
  assign done_tick  = stub_tick | force_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0;
      stub_tick <= 1'b0;
      stub_cnt  <= 0;
      stub_op   <= '0;
      {d3, d2, d1, d0} <= '0;
    end else begin
      stub_tick <= 1'b0;
      if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy <= 1'b0;
          if (!stub_hold) begin
            stub_tick <= 1'b1;
            {d3, d2, d1, d0} <= to_bcd(int'(stub_op));
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end else if (conv_start) begin
        stub_busy <= 1'b1;
        stub_op   <= conv_bin;
        stub_cnt  <= stub_lat;
      end
    end
  end

  typedef struct {
    int          idx;
    logic [N-1:0] reqs;
    int          cyc;
  } ack_ev_t;

  typedef struct {
    int          idx;
    logic [15:0] bcd;
    logic        err;
    int          cyc;
  } done_ev_t;

  ack_ev_t  acks[$];
  done_ev_t dones[$];
  int       starts[$];
  int       viol;
  logic [N-1:0] drop_mask;
  logic     timed_out;
  int       exp_ptr;
  int       tests, fails;
  logic [12:0] ops [N];

  task automatic set_op(input int i, input int v);
    ops[i] = 13'(v);
    bin_in[13*i +: 13] = 13'(v);
  endtask

  task automatic clear_log();
    acks.delete();
    dones.delete();
    starts.delete();
    viol = 0;
  endtask

  // Records one cycle of DUT activity and releases acked requests.
  task automatic observe();
    @(negedge clk);
    if ($countones(ack) + $countones(done) > 1) viol++;
    if (conv_start) starts.push_back(cyc);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        acks.push_back('{i, req, cyc});
        if (drop_mask[i]) req[i] = 1'b0;
      end
      if (done[i]) dones.push_back('{i, bcd_out, err, cyc});
    end
  endtask

  task automatic drive(input int budget);
    int n;
    n = 0;
    timed_out = 1'b0;
    do begin
      observe();
      n++;
    end while (!(req == '0 && !busy) && n < budget);
    if (!(req == '0 && !busy)) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ack, done} !== '0) begin
      fails++;
      $display("FAIL reset_ack_done: got %b/%b want 0", ack, done);
    end
    tests++;
    if ({err, busy, conv_start} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b%b%b want 000",
               err, busy, conv_start);
    end
    tests++;
    if (bcd_out !== 16'h0 || conv_bin !== 13'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h want 0", bcd_out, conv_bin);
    end
    rst_n = 1'b1;
    exp_ptr = 0;
    clear_log();
    repeat (2) observe();
    tests++;
    if (busy !== 1'b0 || acks.size() != 0) begin
      fails++;
      $display("FAIL reset_idle: busy %b acks %0d want 0", busy, acks.size());
    end
  endtask

  task automatic test_all_four();
    int ord [4] = '{0, 1, 2, 3};
    int v   [4] = '{0, 9, 1234, 8191};
    clear_log();
    stub_lat = 4;
    drop_mask = '1;
    for (int i = 0; i < N; i++) set_op(i, v[i]);
    req = '1;
    drive(400);
    tests++;
    if (timed_out || acks.size() != 4 || dones.size() != 4) begin
      fails++;
      $display("FAIL all4_count: acks %0d dones %0d to %b want 4/4/0",
               acks.size(), dones.size(), timed_out);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (acks[k].idx != ord[k] || dones[k].idx != ord[k] ||
            dones[k].bcd !== to_bcd(v[ord[k]]) || dones[k].err !== 1'b0) begin
          fails++;
          $display("FAIL all4_%0d: ack %0d done %0d bcd %h err %b want %0d %h 0",
                   k, acks[k].idx, dones[k].idx, dones[k].bcd,
                   dones[k].err, ord[k], to_bcd(v[ord[k]]));
        end
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (acks[k+1].cyc != dones[k].cyc + 1) begin
          fails++;
          $display("FAIL all4_b2b_%0d: ack cyc %0d want %0d",
                   k, acks[k+1].cyc, dones[k].cyc + 1);
        end
      end
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL all4_onehot: %0d multi-hot cycles want 0", viol);
    end
    exp_ptr = 0;
  endtask

  task automatic test_single();
    clear_log();
    stub_lat = 7;
    set_op(0, 3447);
    req = 4'b0001;
    drive(200);
    tests++;
    if (timed_out || acks.size() != 1 || dones.size() != 1 ||
        starts.size() != 1) begin
      fails++;
      $display("FAIL single_count: acks %0d dones %0d starts %0d want 1/1/1",
               acks.size(), dones.size(), starts.size());
    end else begin
      tests++;
      if (acks[0].idx != 0 || starts[0] != acks[0].cyc + 1) begin
        fails++;
        $display("FAIL single_ack: idx %0d start cyc %0d want 0 at %0d",
                 acks[0].idx, starts[0], acks[0].cyc + 1);
      end
      tests++;
      if (dones[0].idx != 0 || dones[0].bcd !== 16'h3447 ||
          dones[0].err !== 1'b0) begin
        fails++;
        $display("FAIL single_done: idx %0d bcd %h err %b want 0 3447 0",
                 dones[0].idx, dones[0].bcd, dones[0].err);
      end
    end
    tests++;
    if (busy !== 1'b0 || bcd_out !== 16'h3447) begin
      fails++;
      $display("FAIL single_after: busy %b bcd %h want 0 3447", busy, bcd_out);
    end
    exp_ptr = 1;
  endtask

  task automatic test_fairness();
    int want [3] = '{1, 2, 1};
    int n;
    clear_log();
    stub_lat = 3;
    set_op(1, 4711);
    set_op(2, 2024);
    drop_mask = 4'b1101;
    req = 4'b0010;
    n = 0;
    while (n < 300 && !(acks.size() >= 3 && req == '0 && !busy)) begin
      observe();
      n++;
      if (acks.size() == 1 && !req[2] && dones.size() == 0) req[2] = 1'b1;
      if (acks.size() == 2) drop_mask[1] = 1'b1;
    end
    tests++;
    if (acks.size() != 3 || dones.size() != 3) begin
      fails++;
      $display("FAIL fair_count: acks %0d dones %0d want 3/3",
               acks.size(), dones.size());
      req = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (acks[k].idx != want[k] ||
            dones[k].bcd !== to_bcd(int'(ops[want[k]]))) begin
          fails++;
          $display("FAIL fair_%0d: idx %0d bcd %h want %0d %h", k,
                   acks[k].idx, dones[k].bcd, want[k],
                   to_bcd(int'(ops[want[k]])));
        end
      end
    end
    drop_mask = '1;
    exp_ptr = 2;
  endtask

  task automatic test_not_ready();
    int rel;
    clear_log();
    stub_lat = 2;
    force_nr = 1'b1;
    set_op(3, 5006);
    req = 4'b1000;
    repeat (10) observe();
    tests++;
    if (acks.size() != 0 || starts.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL nr_hold: acks %0d starts %0d busy %b want 0 0 0",
               acks.size(), starts.size(), busy);
    end
    force_nr = 1'b0;
    rel = cyc;
    drive(200);
    tests++;
    if (acks.size() != 1 || dones.size() != 1) begin
      fails++;
      $display("FAIL nr_count: acks %0d dones %0d want 1/1",
               acks.size(), dones.size());
    end else begin
      tests++;
      if (acks[0].idx != 3 || acks[0].cyc != rel + 1 ||
          dones[0].bcd !== 16'h5006) begin
        fails++;
        $display("FAIL nr_grant: idx %0d cyc %0d bcd %h want 3 %0d 5006",
                 acks[0].idx, acks[0].cyc, dones[0].bcd, rel + 1);
      end
    end
    exp_ptr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int exp;
    for (int r = 0; r < 8; r++) begin
      clear_log();
      stub_lat = $urandom_range(0, 6);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 8191));
      req = mask;
      drive(600);
      tests++;
      if (timed_out || acks.size() != $countones(mask) ||
          dones.size() != acks.size()) begin
        fails++;
        $display("FAIL rand%0d_count: acks %0d dones %0d want %0d",
                 r, acks.size(), dones.size(), $countones(mask));
        continue;
      end
      for (int k = 0; k < acks.size(); k++) begin
        exp = rr_pick(acks[k].reqs, exp_ptr);
        tests++;
        if (acks[k].idx != exp || dones[k].idx != exp ||
            dones[k].bcd !== to_bcd(int'(ops[exp])) || dones[k].err) begin
          fails++;
          $display("FAIL rand%0d_%0d: ack %0d done %0d bcd %h want %0d %h",
                   r, k, acks[k].idx, dones[k].idx, dones[k].bcd,
                   exp, to_bcd(int'(ops[exp])));
        end
        exp_ptr = (exp + 1) % N;
      end
      tests++;
      if (viol != 0) begin
        fails++;
        $display("FAIL rand%0d_onehot: %0d multi-hot cycles want 0", r, viol);
      end
    end
  endtask

  task automatic test_timeout();
    int nd;
    clear_log();
    stub_hold = 1'b1;
    stub_lat = 1;
    set_op(2, 1234);
    req = 4'b0100;
    drive(300);
    stub_hold = 1'b0;
    tests++;
    if (acks.size() != 1 || dones.size() != 1) begin
      fails++;
      $display("FAIL to_count: acks %0d dones %0d want 1/1",
               acks.size(), dones.size());
    end else begin
      tests++;
      if (dones[0].idx != 2 || dones[0].err !== 1'b1 ||
          dones[0].bcd !== 16'h0) begin
        fails++;
        $display("FAIL to_done: idx %0d err %b bcd %h want 2 1 0000",
                 dones[0].idx, dones[0].err, dones[0].bcd);
      end
      tests++;
      if (dones[0].cyc - acks[0].cyc != TO + 2) begin
        fails++;
        $display("FAIL to_latency: %0d cycles want %0d",
                 dones[0].cyc - acks[0].cyc, TO + 2);
      end
    end
    nd = dones.size();
    force_tick = 1'b1;
    observe();
    force_tick = 1'b0;
    repeat (3) observe();
    tests++;
    if (dones.size() != nd || bcd_out !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL late_tick: dones %0d bcd %h busy %b want %0d 0000 0",
               dones.size(), bcd_out, busy, nd);
    end
    exp_ptr = 3;
  endtask

  task automatic test_reset_mid();
    clear_log();
    stub_lat = 40;
    set_op(1, 4321);
    req = 4'b0010;
    for (int n = 0; n < 50 && acks.size() == 0; n++) observe();
    repeat (5) observe();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || conv_bin !== 13'h0 || ack !== '0 ||
        done !== '0 || conv_start !== 1'b0 || bcd_out !== 16'h0) begin
      fails++;
      $display("FAIL rmid_async: busy %b bin %h ack %b done %b bcd %h want 0",
               busy, conv_bin, ack, done, bcd_out);
    end
    req = 4'b1100;
    set_op(2, 77);
    set_op(3, 8000);
    repeat (3) observe();
    tests++;
    if (acks.size() != 1 || dones.size() != 0) begin
      fails++;
      $display("FAIL rmid_hold: acks %0d dones %0d want 1/0",
               acks.size(), dones.size());
    end
    stub_lat = 3;
    rst_n = 1'b1;
    clear_log();
    drive(300);
    tests++;
    if (acks.size() != 2 || dones.size() != 2) begin
      fails++;
      $display("FAIL rmid_count: acks %0d dones %0d want 2/2",
               acks.size(), dones.size());
    end else begin
      tests++;
      if (acks[0].idx != 2 || acks[1].idx != 3 ||
          dones[0].bcd !== 16'h0077 || dones[1].bcd !== 16'h8000) begin
        fails++;
        $display("FAIL rmid_order: %0d,%0d bcd %h,%h want 2,3 0077,8000",
                 acks[0].idx, acks[1].idx, dones[0].bcd, dones[1].bcd);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req = '0;
    bin_in = '0;
    drop_mask = '1;
    stub_hold = 1'b0;
    stub_lat = 2;
    force_nr = 1'b0;
    force_tick = 1'b0;
    viol = 0;
    exp_ptr = 0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    test_reset();
    test_all_four();
    test_single();
    test_fairness();
    test_not_ready();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter_amisha.md
# bcd_conv_arbiter_amisha

Round-robin arbiter and sequencer that shares one `bin2bcd` FSMD converter among `N_REQ` requesters. It accepts 13-bit binary conversion requests and drives the converter's start/ready/done_tick handshake. It returns the 4-digit BCD result to the requester that owns the conversion, with a watchdog that recovers from a converter that never completes. It sits between display/report clients and the single converter instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max cycles in WAIT before abort (≥ 16)
- `clk_amisha`  in  1  single clock, rising edge
- `reset_amisha`  in  1  asynchronous, active-low reset
- `req_amisha`  in  N_REQ  level request per requester; held until its ack
- `bin_in_amisha`  in  13*N_REQ  flattened operands; requester i at [13i+12:13i]
- `ack_amisha`  out  N_REQ  one-cycle pulse: request i accepted, operand captured
- `done_amisha`  out  N_REQ  one-cycle pulse: result for requester i valid on `bcd_out_amisha`
- `err_amisha`  out  1  high with `done_amisha` when the conversion timed out
- `bcd_out_amisha`  out  16  {bcd3,bcd2,bcd1,bcd0}; holds until next done
- `busy_amisha`  out  1  high in any state other than IDLE
- `conv_start_amisha`  out  1  start pulse to converter
- `conv_bin_amisha`  out  13  operand to converter, stable from START through WAIT
- `conv_ready_amisha`  in  1  converter idle
- `conv_done_tick_amisha`  in  1  converter completion pulse
- `conv_bcd3_amisha`..`conv_bcd0_amisha`  in  4 each  converter result digits

## Operation
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE: if `|req_amisha` and `conv_ready_amisha`, grant the first asserted request at or after pointer `ptr` (wrapping modulo N_REQ).
  - On that edge: latch the owner index and `conv_bin_amisha` ← that requester's operand, pulse `ack_amisha[owner]`, go START.
  - Otherwise stay in IDLE.
- START: `conv_start_amisha`=1 for exactly one cycle; clear the watchdog counter; go WAIT.
- WAIT: on `conv_done_tick_amisha`, capture the four digits into `bcd_out_amisha`, set err=0, go RESP.
  - If the counter reaches TIMEOUT-1 without a done_tick, set `bcd_out_amisha`=16'h0000, err=1, go RESP.
  - A done_tick arriving on the timeout cycle wins: the result is captured and err stays 0.
- RESP: pulse `done_amisha[owner]` (with `err_amisha` if set); `ptr` ← owner+1 mod N_REQ; go IDLE.
- `conv_done_tick_amisha` outside WAIT is ignored.
- A request deasserted before its ack is withdrawn with no side effects. A request still high after its ack counts as a new request.
- Operand not sampled outside the grant edge; operand changes after ack have no effect.
- Reset (async, `reset_amisha`=0): state IDLE, ptr=0, watchdog=0, all outputs 0 (`ack`, `done`, `err`, `busy`, `conv_start`, `conv_bin`, `bcd_out`). Reset mid-conversion discards the owner with no done pulse. The converter is reset by the same signal.

## Timing
- Grant edge E0 (IDLE). ack and `busy_amisha` high in cycle E0–E1. `conv_start_amisha` high in cycle E1–E2.
- Converter done_tick sampled at edge Ed (WAIT). `done_amisha` and `bcd_out_amisha` valid in cycle Ed–Ed+1. Next grant possible at edge Ed+1.
- Overhead per conversion: 3 cycles beyond converter latency. Back-to-back conversions have no idle cycle if a request is pending.
- Fairness: with all requesters asserted, grant order is ptr, ptr+1, …, and each requester waits at most N_REQ-1 other conversions.
- Only one of `ack_amisha`/`done_amisha` bits is high in any cycle; `conv_start_amisha` is never high while `conv_ready_amisha`=0 at grant.

## Test plan
- Single request: req[0] with operand 13'b0110101110111 (3447) → ack[0] 1 cycle, one conv_start, done[0] with bcd_out=16'h3447, err=0, then busy=0.
- All four requesting simultaneously (operands 0, 9, 1234, 8191) → grants in order 0,1,2,3; results 16'h0000, 16'h0009, 16'h1234, 16'h8191.
- Fairness: req[1] held high continuously with req[2] pulsed → order 1,2,1; requester 1 is never granted twice in a row while 2 waits.
- conv_ready_amisha=0 with req[3] high → no ack or conv_start until ready rises; grant occurs on the first edge it is sampled 1.
- Converter stub withholds done_tick → done[owner] exactly TIMEOUT+2 cycles after the ack cycle, with err=1 and bcd_out=0. A late done_tick in IDLE is ignored.
- Reset asserted mid-WAIT → all outputs 0 immediately (asynchronously), no done pulse. After release, a pending request is granted from ptr=0.
